// File: rtl/x_shift_pkg.sv
// rtl/x_shift_pkg.sv - shared word and bit-counter types for the serial deserializer
package x_shift_pkg;
    localparam int WORD_W = 32;
    typedef logic [WORD_W-1:0]         word_t;
    typedef logic [$clog2(WORD_W)-1:0] bitcnt_t;
endpackage

// File: rtl/x_deser_32_bit_if.sv
// rtl/x_deser_32_bit_if.sv - parallel word output handshake of the deserializer
interface x_deser_32_bit_if #(parameter int WIDTH = 32);
    logic [WIDTH-1:0] o_data;
    logic             o_vld;
    logic             i_rdy;

    modport master (output o_data, output o_vld, input i_rdy);
    modport slave  (input o_data, input o_vld, output i_rdy);
endinterface

// File: rtl/x_fifo_2.sv
// rtl/x_fifo_2.sv - two-entry valid/ready FIFO whose head entry is a register
module x_fifo_2 #(
    parameter int W = 32
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_push,
    input  logic [W-1:0] i_data,
    input  logic         i_pop,
    output logic [W-1:0] o_data,
    output logic         o_full,
    output logic         o_empty
);
    logic [W-1:0] mem0;
    logic [W-1:0] mem1;
    logic [1:0]   count;
    logic         pop_ok;
    logic         push_ok;

    // A push into a full buffer is only accepted when a pop frees a slot in the same cycle.
    always_comb begin
        pop_ok  = i_pop && (count != 2'd0);
        push_ok = i_push && ((count != 2'd2) || pop_ok);
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            mem0  <= '0;
            mem1  <= '0;
            count <= 2'd0;
        end else begin
            case (count)
                2'd0: begin
                    if (push_ok) mem0 <= i_data;
                end
                2'd1: begin
                    if (push_ok && pop_ok) mem0 <= i_data;
                    else if (push_ok)      mem1 <= i_data;
                end
                default: begin
                    if (pop_ok) begin
                        mem0 <= mem1;
                        if (push_ok) mem1 <= i_data;
                    end
                end
            endcase
            count <= count + {1'b0, push_ok} - {1'b0, pop_ok};
        end
    end

    // mem0 is left untouched when the last entry pops, so the head holds its last value.
    assign o_data  = mem0;
    assign o_full  = (count == 2'd2);
    assign o_empty = (count == 2'd0);
endmodule

// File: rtl/x_deser_32_bit.sv
// rtl/x_deser_32_bit.sv - serial-to-parallel word assembler with 2-entry output buffer
module x_deser_32_bit
    import x_shift_pkg::*;
#(
    parameter int WIDTH     = WORD_W,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_in,
    input  logic                     i_in_vld,
    input  logic                     i_sync,
    output logic [$clog2(WIDTH)-1:0] o_bit_cnt,
    output logic                     o_ovf,
    input  logic                     i_ovf_clr,
    x_deser_32_bit_if.master         out_if
);
    localparam int CW = $clog2(WIDTH);

    logic [WIDTH-1:0] sr;
    logic [WIDTH-1:0] base;
    logic [WIDTH-1:0] shifted;
    logic [CW-1:0]    cnt;
    logic             complete;
    logic             pend_vld;
    logic [WIDTH-1:0] pend_word;
    logic             full;
    logic             empty;
    logic             pop;
    logic             drop;

    // A sync shifts the current bit into an empty word, so it lands as the first bit.
    always_comb begin
        base     = i_sync ? '0 : sr;
        shifted  = MSB_FIRST ? {base[WIDTH-2:0], i_in} : {i_in, base[WIDTH-1:1]};
        complete = i_in_vld && !i_sync && (cnt == CW'(WIDTH - 1));
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            sr        <= '0;
            cnt       <= '0;
            pend_vld  <= 1'b0;
            pend_word <= '0;
        end else begin
            pend_vld <= complete;
            if (complete) pend_word <= shifted;
            if (i_sync) begin
                sr  <= i_in_vld ? shifted : '0;
                cnt <= i_in_vld ? CW'(1) : '0;
            end else if (i_in_vld) begin
                if (complete) begin
                    sr  <= '0;
                    cnt <= '0;
                end else begin
                    sr  <= shifted;
                    cnt <= cnt + CW'(1);
                end
            end
        end
    end

    // The completed word waits one cycle in pend_word before entering the buffer.
    assign pop  = out_if.o_vld && out_if.i_rdy;
    assign drop = pend_vld && full && !pop;

    x_fifo_2 #(.W(WIDTH)) u_fifo (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_push  (pend_vld),
        .i_data  (pend_word),
        .i_pop   (pop),
        .o_data  (out_if.o_data),
        .o_full  (full),
        .o_empty (empty)
    );

    assign out_if.o_vld = !empty;
    assign o_bit_cnt    = cnt;

    // A drop in the same cycle as a clear leaves the flag set.
    always_ff @(posedge i_clk) begin
        if (i_rst)          o_ovf <= 1'b0;
        else if (drop)      o_ovf <= 1'b1;
        else if (i_ovf_clr) o_ovf <= 1'b0;
    end
endmodule

// File: tb/tb_x_deser_32_bit.sv
// tb/tb_x_deser_32_bit.sv - self-checking bench for x_deser_32_bit
module tb_x_deser_32_bit;
    import x_shift_pkg::*;

    logic    i_clk = 1'b0;
    logic    i_rst;
    logic    i_in;
    logic    i_in_vld;
    logic    i_sync;
    logic    i_ovf_clr;
    bitcnt_t o_bit_cnt;
    logic    o_ovf;

    always #5 i_clk = ~i_clk;

    x_deser_32_bit_if #(.WIDTH(WORD_W)) bus ();

    x_deser_32_bit #(.WIDTH(WORD_W), .MSB_FIRST(1'b1)) dut (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .i_in      (i_in),
        .i_in_vld  (i_in_vld),
        .i_sync    (i_sync),
        .o_bit_cnt (o_bit_cnt),
        .o_ovf     (o_ovf),
        .i_ovf_clr (i_ovf_clr),
        .out_if    (bus.master)
    );

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: partial word as a list of received bits, buffer as a queue of words.
    bit    m_bits[$];
    word_t m_fifo[$];
    bit    m_pend;
    word_t m_pend_word;
    bit    m_ovf;
    word_t m_data;
    bit    m_on = 1'b0;
    word_t got[$];

    always @(posedge i_clk) begin : model
        word_t w;
        if (i_rst) begin
            m_bits.delete();
            m_fifo.delete();
            m_pend = 1'b0;
            m_ovf  = 1'b0;
            m_data = '0;
            m_on   = 1'b1;
        end else begin
            if (m_fifo.size() > 0 && bus.i_rdy) void'(m_fifo.pop_front());
            if (i_ovf_clr) m_ovf = 1'b0;
            if (m_pend) begin
                if (m_fifo.size() < 2) m_fifo.push_back(m_pend_word);
                else                   m_ovf = 1'b1;
            end
            m_pend = 1'b0;
            if (i_sync) begin
                m_bits.delete();
                if (i_in_vld) m_bits.push_back(i_in);
            end else if (i_in_vld) begin
                m_bits.push_back(i_in);
                if (m_bits.size() == WORD_W) begin
                    w = '0;
                    foreach (m_bits[k]) w = w * 2 + word_t'(m_bits[k]);
                    m_pend      = 1'b1;
                    m_pend_word = w;
                    m_bits.delete();
                end
            end
            if (m_fifo.size() > 0) m_data = m_fifo[0];
        end
    end

    always @(negedge i_clk) begin
        if (m_on) begin
            chk("vld", 32'(bus.o_vld), 32'(m_fifo.size() > 0));
            chk("data", bus.o_data, m_data);
            chk("bit_cnt", 32'(o_bit_cnt), 32'(m_bits.size()));
            chk("ovf", 32'(o_ovf), 32'(m_ovf));
            if (bus.o_vld && bus.i_rdy) got.push_back(bus.o_data);
        end
    end

    task automatic step(input bit b, input bit v, input bit s);
        i_in     = b;
        i_in_vld = v;
        i_sync   = s;
        @(posedge i_clk);
        #1;
        i_in_vld  = 1'b0;
        i_sync    = 1'b0;
        i_ovf_clr = 1'b0;
        i_rst     = 1'b0;
    endtask

    task automatic send_word(input word_t w);
        for (int i = WORD_W - 1; i >= 0; i--) step(w[i], 1'b1, 1'b0);
    endtask

    task automatic idle(input int n);
        repeat (n) step(1'b0, 1'b0, 1'b0);
    endtask

    task automatic wait_got(input int n, input int lim);
        int k = 0;
        while (got.size() < n && k < lim) begin
            step(1'b0, 1'b0, 1'b0);
            k++;
        end
        chk("wait_got", 32'(got.size()), 32'(n));
    endtask

    initial begin : stim
        word_t w;
        i_rst = 1'b1; i_in = 1'b0; i_in_vld = 1'b0; i_sync = 1'b0; i_ovf_clr = 1'b0;
        bus.i_rdy = 1'b0;
        step(1'b0, 1'b0, 1'b0);
        chk("rst_vld", 32'(bus.o_vld), 32'd0);
        chk("rst_data", bus.o_data, 32'd0);
        chk("rst_cnt", 32'(o_bit_cnt), 32'd0);
        chk("rst_ovf", 32'(o_ovf), 32'd0);

        // 1: continuous word, one-cycle latency
        bus.i_rdy = 1'b1;
        send_word(32'hA5A5_F00D);
        chk("t1_vld_early", 32'(bus.o_vld), 32'd0);
        chk("t1_cnt_wrap", 32'(o_bit_cnt), 32'd0);
        idle(1);
        chk("t1_vld", 32'(bus.o_vld), 32'd1);
        chk("t1_data", bus.o_data, 32'hA5A5_F00D);
        idle(2);

        // 2: valid toggling every cycle
        got.delete();
        w = 32'h1234_5678;
        for (int i = WORD_W - 1; i >= 0; i--) begin
            step(w[i], 1'b1, 1'b0);
            if (i == 24) chk("t2_cnt_vld", 32'(o_bit_cnt), 32'd8);
            step(1'b0, 1'b0, 1'b0);
            if (i == 24) chk("t2_cnt_hold", 32'(o_bit_cnt), 32'd8);
        end
        wait_got(1, 8);
        if (got.size() > 0) chk("t2_word", got[0], 32'h1234_5678);

        // 3: sync discards a partial word
        got.delete();
        repeat (10) step(1'b1, 1'b1, 1'b0);
        chk("t3_cnt10", 32'(o_bit_cnt), 32'd10);
        step(1'b0, 1'b0, 1'b1);
        chk("t3_cnt_sync", 32'(o_bit_cnt), 32'd0);
        send_word(32'hDEAD_BEEF);
        wait_got(1, 8);
        idle(3);
        chk("t3_count", 32'(got.size()), 32'd1);
        if (got.size() > 0) chk("t3_word", got[0], 32'hDEAD_BEEF);

        // 4: overflow, with a clear in the drop cycle
        got.delete();
        bus.i_rdy = 1'b0;
        send_word(32'h1);
        send_word(32'h2);
        send_word(32'h3);
        i_ovf_clr = 1'b1;
        step(1'b0, 1'b0, 1'b0);
        chk("t4_ovf_set_wins", 32'(o_ovf), 32'd1);
        chk("t4_head", bus.o_data, 32'h1);
        bus.i_rdy = 1'b1;
        wait_got(2, 8);
        if (got.size() > 1) begin
            chk("t4_word0", got[0], 32'h1);
            chk("t4_word1", got[1], 32'h2);
        end
        idle(2);
        chk("t4_count", 32'(got.size()), 32'd2);
        chk("t4_ovf_held", 32'(o_ovf), 32'd1);
        i_ovf_clr = 1'b1;
        step(1'b0, 1'b0, 1'b0);
        chk("t4_ovf_clr", 32'(o_ovf), 32'd0);

        // 5: third word completes as the consumer becomes ready
        got.delete();
        bus.i_rdy = 1'b0;
        send_word(32'h1);
        send_word(32'h2);
        w = 32'h3;
        for (int i = WORD_W - 1; i >= 0; i--) begin
            if (i == 0) bus.i_rdy = 1'b1;
            step(w[i], 1'b1, 1'b0);
        end
        wait_got(3, 10);
        chk("t5_ovf", 32'(o_ovf), 32'd0);
        if (got.size() > 2) begin
            chk("t5_word0", got[0], 32'h1);
            chk("t5_word1", got[1], 32'h2);
            chk("t5_word2", got[2], 32'h3);
        end

        // 6: reset mid-word with words buffered
        got.delete();
        bus.i_rdy = 1'b0;
        send_word(32'hAAAA_0001);
        send_word(32'hBBBB_0002);
        send_word(32'hCCCC_0003);
        repeat (20) step(1'b1, 1'b1, 1'b0);
        chk("t6_pre_ovf", 32'(o_ovf), 32'd1);
        chk("t6_pre_cnt", 32'(o_bit_cnt), 32'd20);
        chk("t6_pre_vld", 32'(bus.o_vld), 32'd1);
        i_rst = 1'b1;
        step(1'b0, 1'b0, 1'b0);
        chk("t6_vld", 32'(bus.o_vld), 32'd0);
        chk("t6_cnt", 32'(o_bit_cnt), 32'd0);
        chk("t6_ovf", 32'(o_ovf), 32'd0);
        chk("t6_data", bus.o_data, 32'd0);
        bus.i_rdy = 1'b1;
        send_word(32'h0F0F_1234);
        wait_got(1, 8);
        idle(3);
        chk("t6_count", 32'(got.size()), 32'd1);
        if (got.size() > 0) chk("t6_word", got[0], 32'h0F0F_1234);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
